adc_packet_parser: RTL and testbench

ADC_PACKET_PARSER -- requirements
Module: adc_packet_parser

---
 rtl/adc_packet_parser_if.sv | 23 ++
 rtl/adc_packet_parser.sv | 172 +++++++++++++++++
 tb/tb_adc_packet_parser.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_packet_parser_if.sv
// Stream bundle for adc_packet_parser: tagged input words and decoded sample output.
// The slave modport is the parser's view; master is the driver/sink side.
interface adc_packet_parser_if;
    localparam int unsigned DATA_W = 32;

    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata
    );
endinterface

// File: rtl/adc_packet_parser.sv
// Parses tagged ADC packets (samples, ts low, ts high+last) into sample beats and a descriptor.
// Define ADC_PARSER_PEAK_EN to track the per-packet peak of |a|+|b|; otherwise desc_peak is 0.
module adc_packet_parser #(
    parameter int unsigned SAMPLE_CNT_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    adc_packet_parser_if.slave          bus,
    output logic                        desc_valid,
    output logic [63:0]                 desc_timestamp,
    output logic [SAMPLE_CNT_WIDTH-1:0] desc_samples,
    output logic [15:0]                 desc_peak,
    output logic [15:0]                 packets_count,
    output logic [15:0]                 errors_count,
    output logic                        err_flag,
    input  logic                        clear_stats
);
    localparam int unsigned CW = SAMPLE_CNT_WIDTH;
    localparam logic [1:0] TAG_SAMPLE = 2'b11;
    localparam logic [1:0] TAG_TS_LO  = 2'b01;
    localparam logic [1:0] TAG_TS_HI  = 2'b10;

    typedef enum logic [1:0] {S_DATA, S_HIGH, S_RESYNC} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [29:0]     ts_lo_q, ts_lo_d;
    logic            m_valid_q, m_valid_d;
    logic [31:0]     m_data_q, m_data_d;
    logic            desc_valid_q, desc_valid_d;
    logic [63:0]     desc_ts_q, desc_ts_d;
    logic [CW-1:0]   desc_samples_q, desc_samples_d;
    logic [15:0]     desc_peak_q, desc_peak_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            err_flag_q, err_flag_d;

    logic            accept_c, sample_acc, pkt_done, err_hit;
    logic [1:0]      tag;
    logic [29:0]     payload;
    logic            last;
    logic [15:0]     a_s16, b_s16;

    assign bus.s_axis_tready = !m_valid_q || bus.m_axis_tready;
    assign accept_c = bus.s_axis_tvalid && bus.s_axis_tready;
    assign tag      = bus.s_axis_tdata[31:30];
    assign payload  = bus.s_axis_tdata[29:0];
    assign last     = bus.s_axis_tlast;
    assign a_s16    = {payload[29], payload[29:15]};
    assign b_s16    = {payload[14], payload[14:0]};

`ifdef ADC_PARSER_PEAK_EN
    logic [15:0] peak_q, abs_a, abs_b, mag;

    assign abs_a = a_s16[15] ? 16'(-a_s16) : a_s16;
    assign abs_b = b_s16[15] ? 16'(-b_s16) : b_s16;
    assign mag   = abs_a + abs_b;

    // Running maximum over accepted samples; restarts at every packet boundary.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                   peak_q <= '0;
        else if (pkt_done || err_hit)   peak_q <= '0;
        else if (sample_acc && mag > peak_q) peak_q <= mag;
    end
`else
    logic [15:0] peak_q;
    assign peak_q = '0;
`endif

    // Packet framing FSM, sample output register and descriptor/stat updates.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ts_lo_d        = ts_lo_q;
        m_valid_d      = m_valid_q && !bus.m_axis_tready;
        m_data_d       = m_data_q;
        desc_valid_d   = 1'b0;
        desc_ts_d      = desc_ts_q;
        desc_samples_d = desc_samples_q;
        desc_peak_d    = desc_peak_q;
        sample_acc     = 1'b0;
        pkt_done       = 1'b0;
        err_hit        = 1'b0;

        if (accept_c) begin
            case (state_q)
                S_DATA: begin
                    if (tag == TAG_SAMPLE && !last) begin
                        sample_acc = 1'b1;
                        m_valid_d  = 1'b1;
                        m_data_d   = {b_s16, a_s16};
                        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                    end else if (tag == TAG_TS_LO && !last) begin
                        ts_lo_d = payload;
                        state_d = S_HIGH;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (tag == TAG_TS_HI && last) begin
                        pkt_done       = 1'b1;
                        desc_valid_d   = 1'b1;
                        desc_ts_d      = {4'b0, payload, ts_lo_q};
                        desc_samples_d = cnt_q;
                        desc_peak_d    = peak_q;
                        cnt_d          = '0;
                        state_d        = S_DATA;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                default: begin
                    if (last) state_d = S_DATA;
                end
            endcase
            if (err_hit) begin
                cnt_d   = '0;
                state_d = last ? S_DATA : S_RESYNC;
            end
        end

        pkt_cnt_d  = pkt_done ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
        err_cnt_d  = (err_hit && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        err_flag_d = err_flag_q | err_hit;
        if (clear_stats) begin
            pkt_cnt_d  = '0;
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= S_DATA;
            cnt_q          <= '0;
            ts_lo_q        <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            desc_valid_q   <= 1'b0;
            desc_ts_q      <= '0;
            desc_samples_q <= '0;
            desc_peak_q    <= '0;
            pkt_cnt_q      <= '0;
            err_cnt_q      <= '0;
            err_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ts_lo_q        <= ts_lo_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            desc_valid_q   <= desc_valid_d;
            desc_ts_q      <= desc_ts_d;
            desc_samples_q <= desc_samples_d;
            desc_peak_q    <= desc_peak_d;
            pkt_cnt_q      <= pkt_cnt_d;
            err_cnt_q      <= err_cnt_d;
            err_flag_q     <= err_flag_d;
        end
    end

    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tdata  = m_data_q;
    assign desc_valid        = desc_valid_q;
    assign desc_timestamp    = desc_ts_q;
    assign desc_samples      = desc_samples_q;
    assign desc_peak         = desc_peak_q;
    assign packets_count     = pkt_cnt_q;
    assign errors_count      = err_cnt_q;
    assign err_flag          = err_flag_q;
endmodule

// File: tb/tb_adc_packet_parser.sv
// Randomised bench for adc_packet_parser against a packet-level pattern model.
module tb_adc_packet_parser;
    localparam int unsigned CW = 32;
`ifdef ADC_PARSER_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          clear_stats = 1'b0;
    logic          desc_valid;
    logic [63:0]   desc_timestamp;
    logic [CW-1:0] desc_samples;
    logic [15:0]   desc_peak, packets_count, errors_count;
    logic          err_flag;

    always #5 aclk = ~aclk;

    adc_packet_parser_if bus_if ();

    adc_packet_parser #(.SAMPLE_CNT_WIDTH(CW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .bus            (bus_if),
        .desc_valid     (desc_valid),
        .desc_timestamp (desc_timestamp),
        .desc_samples   (desc_samples),
        .desc_peak      (desc_peak),
        .packets_count  (packets_count),
        .errors_count   (errors_count),
        .err_flag       (err_flag),
        .clear_stats    (clear_stats)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] ts;
        logic [63:0] samples;
        logic [15:0] peak;
    } desc_t;

    logic [31:0] exp_out[$];
    desc_t       exp_desc[$];
    int          exp_pkts = 0;
    int          exp_errs = 0;
    logic        exp_flag = 1'b0;
    logic [31:0] pkt_w[$];
    logic        pkt_l[$];
    bit          rnd_ready = 1'b0;
    bit          force_low = 1'b0;

    function automatic logic [15:0] sx(input logic [14:0] v);
        return {v[14], v};
    endfunction

    function automatic int mag(input logic [15:0] v);
        int iv;
        iv = int'($signed(v));
        return (iv < 0) ? -iv : iv;
    endfunction

    function automatic void add(input logic [31:0] w, input logic l);
        pkt_w.push_back(w);
        pkt_l.push_back(l);
    endfunction

    function automatic logic [31:0] rnd_word(input logic [1:0] t);
        return {t, 30'($urandom)};
    endfunction

    // Packet shapes: 0 good, others are distinct framing faults.
    function automatic void build(input int kind, input int n);
        pkt_w.delete();
        pkt_l.delete();
        repeat (n) add(rnd_word(2'b11), 1'b0);
        case (kind)
            0: begin add(rnd_word(2'b01), 1'b0); add(rnd_word(2'b10), 1'b1); end
            1: begin add(rnd_word(2'b00), 1'b0); add(rnd_word(2'b11), 1'b0);
                     add(rnd_word(2'b11), 1'b0); add(rnd_word(2'b10), 1'b1); end
            2: add(rnd_word(2'b11), 1'b1);
            3: begin add(rnd_word(2'b01), 1'b0); add(rnd_word(2'b10), 1'b0);
                     add(rnd_word(2'b10), 1'b1); end
            4: begin add(rnd_word(2'b01), 1'b0); add(rnd_word(2'b11), 1'b0);
                     add(rnd_word(2'b10), 1'b1); end
            5: add(rnd_word(2'b10), 1'b1);
            default: add(rnd_word(2'b01), 1'b1);
        endcase
    endfunction

    function automatic void push_sample(input logic [31:0] w);
        exp_out.push_back({sx(w[14:0]), sx(w[29:15])});
    endfunction

    // Good packet == sample* , ts_lo , ts_hi+last. Leading samples always emerge.
    function automatic void model(input bit clr);
        int    lead = 0;
        int    sz = pkt_w.size();
        int    pk = 0;
        bit    good = 1'b0;
        desc_t d;
        while (lead < sz && pkt_w[lead][31:30] == 2'b11 && !pkt_l[lead]) begin
            push_sample(pkt_w[lead]);
            if (mag(sx(pkt_w[lead][29:15])) + mag(sx(pkt_w[lead][14:0])) > pk)
                pk = mag(sx(pkt_w[lead][29:15])) + mag(sx(pkt_w[lead][14:0]));
            lead++;
        end
        if (sz == lead + 2) begin
            if (pkt_w[lead][31:30] == 2'b01 && !pkt_l[lead] &&
                pkt_w[lead+1][31:30] == 2'b10 && pkt_l[lead+1]) good = 1'b1;
        end
        if (good) begin
            d.ts      = {4'b0, pkt_w[lead+1][29:0], pkt_w[lead][29:0]};
            d.samples = 64'(lead);
            d.peak    = PEAK ? 16'(pk) : 16'h0;
            exp_desc.push_back(d);
            exp_pkts = (exp_pkts + 1) % 65536;
        end else begin
            if (exp_errs < 65535) exp_errs++;
            exp_flag = 1'b1;
        end
        if (clr) begin
            exp_pkts = 0;
            exp_errs = 0;
            exp_flag = 1'b0;
        end
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_word(input logic [31:0] d, input logic l, input logic clr);
        int waited = 0;
        bus_if.s_axis_tdata  = d;
        bus_if.s_axis_tlast  = l;
        bus_if.s_axis_tvalid = 1'b1;
        clear_stats          = clr;
        @(negedge aclk);
        while (!bus_if.s_axis_tready && waited < 200) begin
            @(negedge aclk);
            waited++;
        end
        if (!bus_if.s_axis_tready) chk("s_accept_timeout", 64'(waited), 64'd0);
        @(posedge aclk);
        #1;
        bus_if.s_axis_tvalid = 1'b0;
        clear_stats          = 1'b0;
        if (rnd_ready && ($urandom % 3 == 0)) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drive(input bit clr);
        for (int i = 0; i < pkt_w.size(); i++)
            send_word(pkt_w[i], pkt_l[i], clr && (i == pkt_w.size() - 1));
    endtask

    task automatic send_packet(input int kind, input int n, input bit clr);
        build(kind, n);
        model(clr);
        drive(clr);
    endtask

    task automatic directed_packet();
        pkt_w.delete();
        pkt_l.delete();
        repeat (3) add({2'b11, 15'h0005, 15'h7FFD}, 1'b0);
        add({2'b01, 30'h0000_0064}, 1'b0);
        add({2'b10, 30'h1}, 1'b1);
        model(1'b0);
        drive(1'b0);
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while ((exp_out.size() != 0 || exp_desc.size() != 0) && waited < 200) begin
            @(posedge aclk);
            waited++;
        end
        repeat (3) @(posedge aclk);
        #1;
        chk({tag, "_out_left"}, 64'(exp_out.size()), 64'd0);
        chk({tag, "_desc_left"}, 64'(exp_desc.size()), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_packets"}, 64'(packets_count), 64'(exp_pkts));
        chk({tag, "_errors"}, 64'(errors_count), 64'(exp_errs));
        chk({tag, "_err_flag"}, 64'(err_flag), 64'(exp_flag));
    endtask

    task automatic clear_pulse();
        clear_stats = 1'b1;
        @(posedge aclk);
        #1;
        clear_stats = 1'b0;
        exp_pkts = 0;
        exp_errs = 0;
        exp_flag = 1'b0;
    endtask

    // Downstream ready driver.
    initial begin
        bus_if.m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus_if.m_axis_tready = force_low ? 1'b0 :
                                   (rnd_ready ? ($urandom % 4 != 0) : 1'b1);
        end
    end

    // Output and descriptor monitor, sampled mid-cycle.
    initial begin
        desc_t d;
        forever begin
            @(negedge aclk);
            chk("s_tready_rule", 64'(bus_if.s_axis_tready),
                64'(!bus_if.m_axis_tvalid || bus_if.m_axis_tready));
            if (bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
                if (exp_out.size() == 0) chk("m_unexpected", 64'(bus_if.m_axis_tdata), 64'hDEAD);
                else chk("m_tdata", 64'(bus_if.m_axis_tdata), 64'(exp_out.pop_front()));
            end
            if (desc_valid) begin
                if (exp_desc.size() == 0) chk("desc_unexpected", 64'(desc_valid), 64'd0);
                else begin
                    d = exp_desc.pop_front();
                    chk("desc_ts", desc_timestamp, d.ts);
                    chk("desc_samples", 64'(desc_samples), d.samples);
                    chk("desc_peak", 64'(desc_peak), 64'(d.peak));
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge aclk);
        $display("FAIL watchdog: cycles exceeded, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tlast  = 1'b0;
        bus_if.s_axis_tdata  = '0;
        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid", 64'(bus_if.m_axis_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(bus_if.m_axis_tdata), 64'd0);
        chk("rst_desc_valid", 64'(desc_valid), 64'd0);
        chk("rst_desc_ts", desc_timestamp, 64'd0);
        chk("rst_desc_samples", 64'(desc_samples), 64'd0);
        chk("rst_desc_peak", 64'(desc_peak), 64'd0);
        check_stats("rst");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        directed_packet();
        drain("basic");
        chk("basic_ts", desc_timestamp, 64'h0000_0000_4000_0064);
        chk("basic_samples", 64'(desc_samples), 64'd3);
        chk("basic_peak", 64'(desc_peak), PEAK ? 64'd8 : 64'd0);
        chk("basic_packets", 64'(packets_count), 64'd1);
        check_stats("basic");

        fork
            directed_packet();
            begin
                int w = 0;
                @(negedge aclk);
                while (!bus_if.m_axis_tvalid && w < 50) begin @(negedge aclk); w++; end
                force_low = 1'b1;
                repeat (4) @(posedge aclk);
                force_low = 1'b0;
            end
        join
        drain("stall");
        chk("stall_samples", 64'(desc_samples), 64'd3);
        check_stats("stall");

        send_packet(0, 0, 1'b0);
        drain("zero");
        chk("zero_samples", 64'(desc_samples), 64'd0);
        chk("zero_peak", 64'(desc_peak), 64'd0);

        clear_pulse();
        send_packet(1, 2, 1'b0);
        send_packet(0, 3, 1'b0);
        drain("illegal");
        chk("illegal_errors", 64'(errors_count), 64'd1);
        chk("illegal_flag", 64'(err_flag), 64'd1);
        chk("illegal_packets", 64'(packets_count), 64'd1);
        chk("illegal_good_samples", 64'(desc_samples), 64'd3);

        clear_pulse();
        send_packet(2, 2, 1'b0);
        send_packet(0, 2, 1'b0);
        drain("smp_last");
        chk("smp_last_errors", 64'(errors_count), 64'd1);
        chk("smp_last_packets", 64'(packets_count), 64'd1);

        send_packet(0, 2, 1'b1);
        drain("clr_coinc");
        chk("clr_coinc_packets", 64'(packets_count), 64'd0);
        check_stats("clr_coinc");

        send_packet(5, 1, 1'b0);
        drain("pre_rst");
        build(0, 2);
        void'(pkt_w.pop_back());
        void'(pkt_l.pop_back());
        push_sample(pkt_w[0]);
        push_sample(pkt_w[1]);
        drive(1'b0);
        drain("mid_rst");
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_pkts = 0;
        exp_errs = 0;
        exp_flag = 1'b0;
        @(posedge aclk);
        #1;
        send_packet(0, 4, 1'b0);
        drain("post_rst");
        chk("post_rst_errors", 64'(errors_count), 64'd0);
        chk("post_rst_samples", 64'(desc_samples), 64'd4);
        check_stats("post_rst");

        rnd_ready = 1'b1;
        for (int p = 0; p < 80; p++) begin
            kind = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 6));
            send_packet(kind, int'($urandom_range(0, 6)), (kind == 0) && ($urandom % 8 == 0));
        end
        rnd_ready = 1'b0;
        drain("random");
        check_stats("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
